synth_voice_scheduler: RTL
==========================

Name: synth_voice_scheduler

Overview:
- Shares the synthesizer's 8 voice channels between two note sources: the music sequencer and CPU sound effects (MMIO/syscall).
- Allocates a free voice to each note and times its duration in sample ticks.
- Serialises all note-on and note-off events onto the single synth note bus through a valid/ready output register.
- Sits between the note sources and the synthesizer core; all logic runs in the CPU clock domain, with the sample rate arriving as a one-cycle tick enable.

Parameters:
NUM_VOICES, 8, number of voice channels (power of 2, 2..8)
MUSIC_MAX, 6, maximum voices the music source may hold at once; the rest are reserved for CPU
DUR_W, 16, width of duration counters in ticks

Ports:
CLK  in  1  system clock
Reset_n  in  1  synchronous active-low reset
iTick  in  1  one-cycle pulse per sample period
iPause  in  1  freezes all duration counters while high
iStop  in  1  one-cycle pulse: expire every busy voice
iMusValid  in  1  music note request
oMusReady  out  1  music request accepted this cycle (combinational)
iMusNote  in  18+DUR_W  {inst[3:0], volume[6:0], pitch[6:0], dur[DUR_W-1:0]}
iCpuValid  in  1  CPU note request
oCpuReady  out  1  CPU request accepted this cycle (combinational)
iCpuNote  in  18+DUR_W  same format as iMusNote
oEvtValid  out  1  note event available
iEvtReady  in  1  synth core consumes event
oSynth  out  8  {pitch, on}
oSynthVolume  out  7  event volume
oSynthInst  out  4  event instrument
oVoice  out  3  voice index of event
oBusyMask  out  NUM_VOICES  voice busy flags

Behaviour:
- Reset (sync, Reset_n=0 at a CLK edge):
  - All voices become free, not expired, counters 0.
  - oEvtValid=0; oSynth, oSynthVolume, oSynthInst, oVoice = 0; oBusyMask=0.
  - A reset mid-operation emits no note-offs.
- Per-voice state: busy, expired, owner (0=music, 1=CPU), pitch, inst, counter[DUR_W].
- Output register free (OF) = !oEvtValid || iEvtReady.
- Each cycle at most one event loads the output register. Fixed priority:
  1. Note-off: lowest-index voice with expired=1, when OF.
  2. CPU request: oCpuReady = iCpuValid && OF && no expired voice pending && a free voice exists.
  3. Music request: oMusReady = iMusValid && !iCpuValid && OF && no expired pending && a free voice exists && music-owned count < MUSIC_MAX.
- Note-on, on accept in cycle N:
  - Lowest-index free voice becomes busy and records owner, pitch and inst.
  - counter = dur; dur=0 is loaded as 1.
  - At N+1: oEvtValid=1, oSynth={pitch, volume!=0}, oSynthVolume=volume, oSynthInst=inst, oVoice=index.
- Note-off, on load in cycle N:
  - At N+1: oSynth={pitch,0}, oSynthVolume=0, oSynthInst=stored inst.
  - The voice is freed (busy=0, expired=0) at N+1.
- Output register holds its contents while oEvtValid && !iEvtReady.
  - When iEvtReady is asserted and nothing new loads, oEvtValid drops next cycle.
- Ticks (iTick && !iPause): every busy, non-expired voice decrements its counter.
  - A decrement from 1 to 0 sets expired at the next edge.
  - A voice allocated in the same cycle is not decremented.
  - iTick while iPause=1 is ignored; ticks are not accumulated.
- iStop: every busy voice gets expired=1 at the next edge.
  - Expired voices drain as note-offs one per accepted event, lowest index first.
  - Requests are blocked until no expired voice remains.
  - iStop with no busy voices has no effect.
- Simultaneous iStop and request: the request is still granted if the grant conditions hold; that voice is not expired by this iStop.
- Latency:
  - Request accept to event valid: 1 cycle.
  - Expiring tick to note-off valid: 2 cycles, if the output register is free.
- oBusyMask reflects registered busy flags.
- Arithmetic: the counter never underflows. The music-owned count is recomputed combinationally from the owner and busy flags.

Test Plan:
- Reset, then music note pitch=60, vol=100, inst=2, dur=3 with iEvtReady=1 → next cycle event oSynth=8'h79, vol=100, inst=2, oVoice=0, oBusyMask=8'h01. After the 3rd tick, 2 cycles later: oSynth=8'h78, vol=0, oVoice=0; oBusyMask=0 one cycle after the note-off is loaded.
- Music holds iMusValid with 7 notes, dur=100 → exactly 6 accepts (voices 0-5); oMusReady stays 0. A CPU note then takes voice 6, another CPU note takes voice 7; a further CPU request is not accepted until a voice frees.
- iMusValid and iCpuValid asserted in the same cycle → only oCpuReady=1; the first event carries the CPU pitch, the music note follows the next cycle.
- iEvtReady=0 with a pending event and a second valid request → oCpuReady/oMusReady=0 and the output is held stable. On iEvtReady=1 the next request is accepted that cycle.
- 4 voices busy, pulse iStop → 4 note-offs on oVoice 0,1,2,3 in consecutive cycles (iEvtReady=1) with requests blocked meanwhile; oBusyMask=0 afterwards.
- dur=0 note, then iPause=1 with 5 ticks → no note-off. iPause=0 plus 1 tick → note-off 2 cycles later. Reset_n=0 mid-note → all outputs 0, no note-off emitted.

Source files
------------

// File: rtl/synth_voice_scheduler.sv
// Voice allocator and note-event serialiser shared by the music sequencer and CPU sound effects.
// Voices are timed in sample ticks and all note-on/off events leave through one valid/ready register.
module synth_voice_scheduler #(
  parameter int NUM_VOICES = 8,
  parameter int MUSIC_MAX  = 6,
  parameter int DUR_W      = 16
) (
  input  logic                    CLK,
  input  logic                    Reset_n,
  input  logic                    iTick,
  input  logic                    iPause,
  input  logic                    iStop,
  input  logic                    iMusValid,
  output logic                    oMusReady,
  input  logic [18+DUR_W-1:0]     iMusNote,
  input  logic                    iCpuValid,
  output logic                    oCpuReady,
  input  logic [18+DUR_W-1:0]     iCpuNote,
  output logic                    oEvtValid,
  input  logic                    iEvtReady,
  output logic [7:0]              oSynth,
  output logic [6:0]              oSynthVolume,
  output logic [3:0]              oSynthInst,
  output logic [2:0]              oVoice,
  output logic [NUM_VOICES-1:0]   oBusyMask
);

  localparam int NOTE_W = 18 + DUR_W;

  logic [NUM_VOICES-1:0] busy;
  logic [NUM_VOICES-1:0] expired;
  logic [NUM_VOICES-1:0] owner;
  logic [6:0]            pitch   [NUM_VOICES];
  logic [3:0]            inst    [NUM_VOICES];
  logic [DUR_W-1:0]      counter [NUM_VOICES];

  logic              outFree, tickEn, offLoad, accept;
  logic              anyExpired, anyFree;
  logic [2:0]        expIdx, freeIdx;
  logic [3:0]        musCount;
  logic [NOTE_W-1:0] reqNote;
  logic [3:0]        reqInst;
  logic [6:0]        reqVol, reqPitch;
  logic [DUR_W-1:0]  reqDur;

  // Scanning downwards leaves the lowest matching index in the result.
  always_comb begin
    anyExpired = 1'b0;
    anyFree    = 1'b0;
    expIdx     = '0;
    freeIdx    = '0;
    musCount   = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (expired[i]) begin
        anyExpired = 1'b1;
        expIdx     = 3'(i);
      end
      if (!busy[i]) begin
        anyFree = 1'b1;
        freeIdx = 3'(i);
      end
      if (busy[i] && !owner[i]) musCount = musCount + 4'd1;
    end
  end

  assign outFree   = !oEvtValid || iEvtReady;
  assign tickEn    = iTick && !iPause;
  assign offLoad   = outFree && anyExpired;
  assign oCpuReady = iCpuValid && outFree && !anyExpired && anyFree;
  assign oMusReady = iMusValid && !iCpuValid && outFree && !anyExpired && anyFree
                     && (musCount < 4'(MUSIC_MAX));
  assign accept    = oCpuReady || oMusReady;
  assign reqNote   = oCpuReady ? iCpuNote : iMusNote;
  assign reqInst   = reqNote[NOTE_W-1 -: 4];
  assign reqVol    = reqNote[DUR_W+13 -: 7];
  assign reqPitch  = reqNote[DUR_W+6 -: 7];
  assign reqDur    = reqNote[DUR_W-1:0];
  assign oBusyMask = busy;

  // Freeing and allocation come after the tick/stop loop so they override it for their voice.
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      busy    <= '0;
      expired <= '0;
      owner   <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        pitch[i]   <= '0;
        inst[i]    <= '0;
        counter[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (busy[i] && !expired[i]) begin
          if (iStop) begin
            expired[i] <= 1'b1;
          end else if (tickEn && counter[i] != '0) begin
            counter[i] <= counter[i] - DUR_W'(1);
            if (counter[i] == DUR_W'(1)) expired[i] <= 1'b1;
          end
        end
      end
      if (offLoad) begin
        busy[expIdx]    <= 1'b0;
        expired[expIdx] <= 1'b0;
      end else if (accept) begin
        busy[freeIdx]    <= 1'b1;
        expired[freeIdx] <= 1'b0;
        owner[freeIdx]   <= oCpuReady;
        pitch[freeIdx]   <= reqPitch;
        inst[freeIdx]    <= reqInst;
        counter[freeIdx] <= (reqDur == '0) ? DUR_W'(1) : reqDur;
      end
    end
  end

  // A note-off always wins the output register over a new note-on.
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      oEvtValid    <= 1'b0;
      oSynth       <= '0;
      oSynthVolume <= '0;
      oSynthInst   <= '0;
      oVoice       <= '0;
    end else if (offLoad) begin
      oEvtValid    <= 1'b1;
      oSynth       <= {pitch[expIdx], 1'b0};
      oSynthVolume <= '0;
      oSynthInst   <= inst[expIdx];
      oVoice       <= expIdx;
    end else if (accept) begin
      oEvtValid    <= 1'b1;
      oSynth       <= {reqPitch, reqVol != 7'd0};
      oSynthVolume <= reqVol;
      oSynthInst   <= reqInst;
      oVoice       <= freeIdx;
    end else if (iEvtReady) begin
      oEvtValid <= 1'b0;
    end
  end

endmodule
